// File: rtl/key_event_encoder.sv
// Keypad event encoder: debounces the 27 keys seen by the row scanner and queues
// press codes 1..27 in a small FIFO drained through a valid/ready handshake.
module key_event_encoder #(
    parameter int unsigned TICK_DIV     = 1024,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [4:0]  switches [0:5],
    output logic [4:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [26:0] key_down,
    output logic        overflow
);
    localparam int unsigned NKEYS = 27;
    localparam int unsigned TW    = $clog2(TICK_DIV);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;
    logic [NKEYS-1:0] w_raw;
    logic             w_unused_bits;

    logic [3:0]       r_cnt      [NKEYS];
    logic [3:0]       w_cnt_next [NKEYS];
    logic [NKEYS-1:0] r_key_down;
    logic [NKEYS-1:0] w_down_next;
    logic [NKEYS-1:0] w_press;

    logic [NKEYS-1:0] r_pending;
    logic [NKEYS-1:0] w_sel_mask;
    logic [NKEYS-1:0] w_clear;
    logic [4:0]       w_sel_code;
    logic             w_found;

    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic             r_overflow;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Row 4 col 4 and row 5 cols 1/3 have no physical key behind them.
    assign w_unused_bits = ^{switches[4][4], switches[5][1], switches[5][3]};

    always_comb begin
        w_raw = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 5; c++) begin
                w_raw[5*r + c] = switches[r][c];
            end
        end
        w_raw[23:20] = switches[4][3:0];
        w_raw[24]    = switches[5][0];
        w_raw[25]    = switches[5][2];
        w_raw[26]    = switches[5][4];
    end

    always_comb begin
        for (int unsigned k = 0; k < NKEYS; k++) begin
            w_down_next[k] = r_key_down[k];
            w_cnt_next[k]  = r_cnt[k];
            if (w_tick) begin
                if (w_raw[k] == r_key_down[k]) begin
                    w_cnt_next[k] = '0;
                end else if (({1'b0, r_cnt[k]} + 5'd1) == 5'(STABLE_TICKS)) begin
                    w_down_next[k] = w_raw[k];
                    w_cnt_next[k]  = '0;
                end else begin
                    w_cnt_next[k] = r_cnt[k] + 4'd1;
                end
            end
        end
    end

    assign w_press = w_down_next & ~r_key_down;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key_down <= '0;
            for (int unsigned k = 0; k < NKEYS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_key_down <= w_down_next;
            for (int unsigned k = 0; k < NKEYS; k++) begin
                r_cnt[k] <= w_cnt_next[k];
            end
        end
    end

    always_comb begin
        w_found    = 1'b0;
        w_sel_code = '0;
        w_sel_mask = '0;
        for (int unsigned k = 0; k < NKEYS; k++) begin
            if (r_pending[k] && !w_found) begin
                w_found       = 1'b1;
                w_sel_code    = 5'(k + 1);
                w_sel_mask[k] = 1'b1;
            end
        end
    end

    assign w_pop   = key_valid && key_ready;
    // Count never exceeds depth, so a pop always frees room for this cycle's push.
    assign w_push  = w_found && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
    assign w_clear = w_push ? w_sel_mask : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_press;
            if (|(r_pending & ~w_clear & w_press)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sel_code;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign key_valid = (r_count != '0);
    assign key_code  = key_valid ? r_mem[r_rd_ptr] : '0;
    assign key_down  = r_key_down;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: key-map table plus hand-written bounce,
// simultaneous-press, back-pressure/coalesce and reset sequences.
module tb_key_event_encoder;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        key_ready = 1'b0;
    logic [4:0]  sw [0:5];
    logic [4:0]  key_code;
    logic        key_valid;
    logic [26:0] key_down;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned ph;

    typedef struct {
        int unsigned row;
        int unsigned col;
        int unsigned code;
    } vec_t;
    vec_t vec [13];

    key_event_encoder #(
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .switches (sw),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_down (key_down),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Phase of the debounce tick, used only to align stimulus to tick edges.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) ph <= 0;
        else       ph <= (ph == TD - 1) ? 0 : ph + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        @(negedge clk);
        while (ph != TD - 1) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) next_tick();
    endtask

    task automatic clear_sw();
        for (int unsigned r = 0; r < 6; r++) sw[r] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned exp_code;
        logic [31:0] exp_down;
        int unsigned drain [6];
        int unsigned simul [3];

        vec[0]  = '{0, 0, 1};
        vec[1]  = '{0, 4, 5};
        vec[2]  = '{1, 2, 8};
        vec[3]  = '{2, 3, 14};
        vec[4]  = '{3, 4, 20};
        vec[5]  = '{4, 0, 21};
        vec[6]  = '{4, 3, 24};
        vec[7]  = '{4, 4, 0};
        vec[8]  = '{5, 0, 25};
        vec[9]  = '{5, 1, 0};
        vec[10] = '{5, 2, 26};
        vec[11] = '{5, 3, 0};
        vec[12] = '{5, 4, 27};
        drain = '{1, 2, 3, 6, 7, 8};
        simul = '{5, 21, 27};

        clear_sw();
        #1;
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_down", key_down, 0);
        chk("rst_ovf", overflow, 0);
        #22 nrst = 1'b1;

        // Key map: one switch at a time, including ignored positions.
        for (int i = 0; i < 13; i++) begin
            exp_code = vec[i].code;
            exp_down = (exp_code == 0) ? 32'd0 : (32'd1 << (exp_code - 1));
            sw[vec[i].row][vec[i].col] = 1'b1;
            ticks(ST - 1);
            chk("map_down_early", key_down, 0);
            next_tick();
            chk("map_down", key_down, exp_down);
            chk("map_valid_E", key_valid, 0);
            step();
            chk("map_valid_E1", key_valid, exp_code != 0);
            chk("map_code_E1", key_code, exp_code);
            key_ready = 1'b1;
            step();
            key_ready = 1'b0;
            chk("map_valid_pop", key_valid, 0);
            chk("map_code_pop", key_code, 0);
            sw[vec[i].row][vec[i].col] = 1'b0;
            ticks(ST);
            chk("map_release", key_down, 0);
            step();
            chk("map_no_release_code", key_valid, 0);
        end

        // Bounce rejection on key 14.
        begin
            logic pat [5];
            pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            for (int j = 0; j < 5; j++) begin
                sw[2][3] = pat[j];
                next_tick();
                chk("bounce_hold", key_down[13], 0);
            end
        end
        next_tick();
        chk("bounce_down", key_down[13], 1);
        step();
        chk("bounce_valid", key_valid, 1);
        chk("bounce_code", key_code, 14);
        key_ready = 1'b1;
        step();
        step();
        key_ready = 1'b0;
        chk("bounce_single", key_valid, 0);
        sw[2][3] = 1'b0;
        ticks(ST);

        // Simultaneous presses of 27, 5, 21.
        sw[5][4] = 1'b1;
        sw[0][4] = 1'b1;
        sw[4][0] = 1'b1;
        ticks(ST);
        chk("simul_down", key_down, (32'd1 << 26) | (32'd1 << 4) | (32'd1 << 20));
        step();
        chk("simul_first", key_code, 5);
        step();
        step();
        chk("simul_head_held", key_code, 5);
        key_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("simul_order", key_code, simul[j]);
            step();
        end
        key_ready = 1'b0;
        chk("simul_count3", key_valid, 0);
        clear_sw();
        ticks(ST);

        // Back-pressure: six keys, FIFO holds four; then coalesce key 8.
        sw[0][2:0] = 3'b111;
        sw[1][2:0] = 3'b111;
        ticks(ST);
        repeat (6) step();
        chk("full_valid", key_valid, 1);
        chk("full_head", key_code, 1);
        chk("full_ovf", overflow, 0);
        sw[1][2] = 1'b0;
        ticks(ST);
        chk("coal_release", key_down[7], 0);
        chk("coal_ovf_pre", overflow, 0);
        sw[1][2] = 1'b1;
        ticks(ST);
        chk("coal_repress", key_down[7], 1);
        step();
        chk("coal_ovf", overflow, 1);
        key_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("drain_order", key_code, drain[j]);
            step();
        end
        repeat (3) begin
            chk("drain_empty", key_valid, 0);
            step();
        end
        key_ready = 1'b0;
        clear_sw();
        ticks(ST);

        // Reset mid-operation with two queued codes.
        sw[1][4] = 1'b1;
        sw[2][0] = 1'b1;
        ticks(ST);
        step();
        step();
        chk("pre_rst_valid", key_valid, 1);
        chk("pre_rst_code", key_code, 10);
        #3 nrst = 1'b0;
        #1;
        chk("midrst_valid", key_valid, 0);
        chk("midrst_code", key_code, 0);
        chk("midrst_down", key_down, 0);
        chk("midrst_ovf", overflow, 0);
        clear_sw();
        @(negedge clk);
        nrst = 1'b1;
        ticks(ST + 1);
        chk("post_rst_valid", key_valid, 0);
        chk("post_rst_down", key_down, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
